// File: rtl/fp_classify_pkg.sv
// Shared class encoding and helpers for the fp_classify_pipe slice.
// Class bit order follows RISC-V fclass.
package fp_classify_pkg;

   localparam int unsigned NUM_CLASSES = 10;

   typedef enum logic [3:0] {
      CLS_NEG_INF      = 4'd0,
      CLS_NEG_NORMAL   = 4'd1,
      CLS_NEG_DENORMAL = 4'd2,
      CLS_NEG_ZERO     = 4'd3,
      CLS_POS_ZERO     = 4'd4,
      CLS_POS_DENORMAL = 4'd5,
      CLS_POS_NORMAL   = 4'd6,
      CLS_POS_INF      = 4'd7,
      CLS_SNAN         = 4'd8,
      CLS_QNAN         = 4'd9
   } class_idx_e;

   typedef logic [NUM_CLASSES-1:0] class_vec_t;

   // Number of set bits across up to 16 lanes.
   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_classify_lane.sv
// Combinational single-operand IEEE-754 classifier producing a one-hot
// fclass-ordered vector; daz folds denormals onto signed zero.
module fp_classify_lane
   import fp_classify_pkg::*;
#(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned MANT_W = 10
) (
   input  logic [EXP_W+MANT_W:0] op_i,
   input  logic                  daz_i,
   output class_vec_t            class_o
);

   logic              sign;
   logic [EXP_W-1:0]  expo;
   logic [MANT_W-1:0] mant;

   assign {sign, expo, mant} = op_i;

   always_comb begin
      class_o = '0;
      if (expo == '1) begin
         if (mant == '0)          class_o[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
         else if (mant[MANT_W-1]) class_o[CLS_QNAN] = 1'b1;
         else                     class_o[CLS_SNAN] = 1'b1;
      end else if (expo == '0) begin
         if (mant == '0 || daz_i) class_o[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
         else                     class_o[sign ? CLS_NEG_DENORMAL : CLS_POS_DENORMAL] = 1'b1;
      end else begin
         class_o[sign ? CLS_NEG_NORMAL : CLS_POS_NORMAL] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_classify_pipe.sv
// Two-stage valid/ready IEEE-754 classifier, LANES operands per beat.
// Define FP_CLASSIFY_STATS_EN to add saturating per-class counters.
module fp_classify_pipe
   import fp_classify_pkg::*;
#(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned MANT_W = 10,
   parameter int unsigned LANES  = 1
`ifdef FP_CLASSIFY_STATS_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  daz,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [LANES*(1+EXP_W+MANT_W)-1:0]     in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [LANES*NUM_CLASSES-1:0]          out_class
`ifdef FP_CLASSIFY_STATS_EN
   ,
   input  logic                                  stats_clr,
   output logic [NUM_CLASSES*CNT_W-1:0]          stats_cnt
`endif
);

   localparam int unsigned W = 1 + EXP_W + MANT_W;

   logic                           s1_valid_q, s1_valid_d;
   logic [LANES*W-1:0]             s1_data_q, s1_data_d;
   logic                           s1_daz_q, s1_daz_d;
   logic                           out_valid_q, out_valid_d;
   logic [LANES*NUM_CLASSES-1:0]   out_class_q, out_class_d;
   logic [LANES*NUM_CLASSES-1:0]   lane_class;
   logic                           s2_ready;

   assign s2_ready  = !out_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_ready;
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fp_classify_lane #(
         .EXP_W  (EXP_W),
         .MANT_W (MANT_W)
      ) u_lane (
         .op_i    (s1_data_q[g*W +: W]),
         .daz_i   (s1_daz_q),
         .class_o (lane_class[g*NUM_CLASSES +: NUM_CLASSES])
      );
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_daz_d    = s1_daz_q;
      out_valid_d = out_valid_q;
      out_class_d = out_class_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_daz_d  = daz;
         end
      end
      if (s2_ready) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) out_class_d = lane_class;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_daz_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_class_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_daz_q    <= s1_daz_d;
         out_valid_q <= out_valid_d;
         out_class_q <= out_class_d;
      end
   end

`ifdef FP_CLASSIFY_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
   logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
   logic [15:0]      hits;
   logic [CNT_W+4:0] sum;
   logic             fire;

   assign fire = out_valid_q && out_ready;

   // Widen before adding so a full beat of hits cannot wrap before saturation.
   always_comb begin
      hits = '0;
      sum  = '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         hits = '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            hits[i] = out_class_q[i*NUM_CLASSES + k];
         end
         sum = (CNT_W+5)'(cnt_q[k]) + (CNT_W+5)'(popcount(hits));
         if (stats_clr)                              cnt_d[k] = '0;
         else if (!fire)                             cnt_d[k] = cnt_q[k];
         else if (sum > {5'b0, {CNT_W{1'b1}}})       cnt_d[k] = '1;
         else                                        cnt_d[k] = sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         if (rst) cnt_q[k] <= '0;
         else     cnt_q[k] <= cnt_d[k];
      end
   end

   always_comb begin
      stats_cnt = '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         stats_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_fp_classify_pipe.sv
// Directed self-checking bench: fp16 single-lane and fp32 four-lane instances.
// Counter checks are compiled in when FP_CLASSIFY_STATS_EN is defined.
module tb_fp_classify_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   logic         v16, rdy16, daz16, or16, ov16;
   logic [15:0]  d16;
   logic [9:0]   cls16;
   logic         v32, rdy32, daz32, or32, ov32;
   logic [127:0] d32;
   logic [39:0]  cls32;
`ifdef FP_CLASSIFY_STATS_EN
   logic         clr16, clr32;
   logic [39:0]  cnt16;
   logic [319:0] cnt32;
   logic [39:0]  ecnt16;
   int unsigned  ecnt32 [10] = '{2, 1, 2, 1, 1, 1, 3, 1, 2, 2};
`endif

   fp_classify_pipe #(
      .EXP_W  (5),
      .MANT_W (10),
      .LANES  (1)
`ifdef FP_CLASSIFY_STATS_EN
      ,
      .CNT_W  (4)
`endif
   ) dut16 (
      .clk       (clk),
      .rst       (rst),
      .daz       (daz16),
      .in_valid  (v16),
      .in_ready  (rdy16),
      .in_data   (d16),
      .out_valid (ov16),
      .out_ready (or16),
      .out_class (cls16)
`ifdef FP_CLASSIFY_STATS_EN
      ,
      .stats_clr (clr16),
      .stats_cnt (cnt16)
`endif
   );

   fp_classify_pipe #(
      .EXP_W  (8),
      .MANT_W (23),
      .LANES  (4)
   ) dut32 (
      .clk       (clk),
      .rst       (rst),
      .daz       (daz32),
      .in_valid  (v32),
      .in_ready  (rdy32),
      .in_data   (d32),
      .out_valid (ov32),
      .out_ready (or32),
      .out_class (cls32)
`ifdef FP_CLASSIFY_STATS_EN
      ,
      .stats_clr (clr32),
      .stats_cnt (cnt32)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Entered just after a posedge with dut16 empty; leaves it empty the same way.
   task automatic single16(input logic [15:0] d, input logic dz, input logic [9:0] exp, input int idx);
      v16 = 1'b1; d16 = d; daz16 = dz;
      @(posedge clk); #1 v16 = 1'b0;
      @(negedge clk); check($sformatf("lat1 v%0d", idx), 64'(ov16), 64'd0);
      @(posedge clk);
      @(negedge clk); check($sformatf("lat2 v%0d", idx), 64'(ov16), 64'd1);
      check($sformatf("class v%0d", idx), 64'(cls16), 64'(exp));
      @(posedge clk); #1;
   endtask

   logic [15:0] vin  [12] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01, 16'h3C00, 16'h0001,
                              16'h0001, 16'h8001, 16'h8000, 16'hFE00, 16'h8001, 16'hBC00};
   logic        vdaz [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [9:0]  vexp [12] = '{10'h080, 10'h001, 10'h200, 10'h100, 10'h040, 10'h020,
                              10'h010, 10'h008, 10'h008, 10'h200, 10'h004, 10'h002};

   logic [31:0] b32 [4][4] = '{
      '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000},
      '{32'h80000001, 32'h00000001, 32'hBF800000, 32'h7F800001},
      '{32'h80000000, 32'h3F800000, 32'hFFC00000, 32'h7FBFFFFF},
      '{32'h00800000, 32'h7F7FFFFF, 32'h807FFFFF, 32'hFF800000}};
   logic [9:0]  e32 [4][4] = '{
      '{10'h080, 10'h001, 10'h010, 10'h200},
      '{10'h004, 10'h020, 10'h002, 10'h100},
      '{10'h008, 10'h040, 10'h200, 10'h100},
      '{10'h040, 10'h040, 10'h004, 10'h001}};

   logic [15:0] bp_in  [3] = '{16'h3C00, 16'hFC00, 16'h7E00};
   logic [9:0]  bp_exp [3] = '{10'h040, 10'h001, 10'h200};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      v16 = 1'b0; d16 = '0; daz16 = 1'b0; or16 = 1'b1;
      v32 = 1'b0; d32 = '0; daz32 = 1'b0; or32 = 1'b1;
`ifdef FP_CLASSIFY_STATS_EN
      clr16 = 1'b0; clr32 = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst ov16", 64'(ov16), 64'd0);
      check("rst cls16", 64'(cls16), 64'd0);
      check("rst rdy16", 64'(rdy16), 64'd1);
      check("rst ov32", 64'(ov32), 64'd0);
      check("rst cls32", 64'(cls32), 64'd0);
`ifdef FP_CLASSIFY_STATS_EN
      check("rst cnt16", 64'(cnt16), 64'd0);
`endif
      @(posedge clk); #1;

      // fp16 single-beat vectors, exact two-cycle latency
      for (int i = 0; i < 12; i++) single16(vin[i], vdaz[i], vexp[i], i);

      // daz is captured per beat; changing it while a beat is in flight has no effect
      v16 = 1'b1; d16 = 16'h0001; daz16 = 1'b1;
      @(posedge clk); #1 daz16 = 1'b0;
      @(posedge clk); #1 v16 = 1'b0; daz16 = 1'b1;
      @(negedge clk); check("daz beat0", 64'(cls16), 64'h010);
      @(posedge clk); #1 daz16 = 1'b0;
      @(negedge clk); check("daz beat1 valid", 64'(ov16), 64'd1);
      check("daz beat1", 64'(cls16), 64'h020);
      @(posedge clk); #1;
      @(negedge clk); check("daz drained", 64'(ov16), 64'd0);
      @(posedge clk); #1;

      // fp32 x4 back-to-back: one result per cycle
      for (int b = 0; b < 6; b++) begin
         if (b < 4) begin
            v32 = 1'b1;
            for (int l = 0; l < 4; l++) d32[l*32 +: 32] = b32[b][l];
         end else begin
            v32 = 1'b0;
         end
         @(negedge clk);
         if (b < 4) check($sformatf("b2b rdy b%0d", b), 64'(rdy32), 64'd1);
         if (b == 1) check("b2b early ov", 64'(ov32), 64'd0);
         if (b >= 2) begin
            check($sformatf("b2b ov b%0d", b - 2), 64'(ov32), 64'd1);
            for (int l = 0; l < 4; l++)
               check($sformatf("b2b b%0d l%0d", b - 2, l), 64'(cls32[l*10 +: 10]), 64'(e32[b-2][l]));
         end
         @(posedge clk); #1;
      end
      @(negedge clk); check("b2b drained", 64'(ov32), 64'd0);
`ifdef FP_CLASSIFY_STATS_EN
      for (int k = 0; k < 10; k++)
         check($sformatf("cnt32 k%0d", k), 64'(cnt32[k*32 +: 32]), 64'(ecnt32[k]));
`endif
      @(posedge clk); #1;

      // Backpressure: three beats, consumer stalled
      or16 = 1'b0;
      v16 = 1'b1; d16 = bp_in[0];
      @(negedge clk); check("bp rdy0", 64'(rdy16), 64'd1);
      @(posedge clk); #1 d16 = bp_in[1];
      @(negedge clk); check("bp rdy1", 64'(rdy16), 64'd1);
      @(posedge clk); #1 d16 = bp_in[2];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("bp stall rdy c%0d", c), 64'(rdy16), 64'd0);
         check($sformatf("bp stall ov c%0d", c), 64'(ov16), 64'd1);
         check($sformatf("bp stall cls c%0d", c), 64'(cls16), 64'(bp_exp[0]));
         @(posedge clk); #1;
      end
      or16 = 1'b1;
      @(negedge clk); check("bp release rdy", 64'(rdy16), 64'd1);
      check("bp out0", 64'(cls16), 64'(bp_exp[0]));
      @(posedge clk); #1 v16 = 1'b0;
      for (int j = 1; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("bp ov%0d", j), 64'(ov16), 64'd1);
         check($sformatf("bp out%0d", j), 64'(cls16), 64'(bp_exp[j]));
         @(posedge clk); #1;
      end
      @(negedge clk); check("bp no dup", 64'(ov16), 64'd0);
      @(posedge clk); #1;

      // Reset with two beats in flight
      v16 = 1'b1; d16 = 16'h3C00;
      @(posedge clk); #1 d16 = 16'hFC00;
      @(posedge clk); #1 v16 = 1'b0; rst = 1'b1;
      @(negedge clk); check("mid pre-rst ov", 64'(ov16), 64'd1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid rst ov", 64'(ov16), 64'd0);
      check("mid rst rdy", 64'(rdy16), 64'd1);
      check("mid rst cls", 64'(cls16), 64'd0);
`ifdef FP_CLASSIFY_STATS_EN
      check("mid rst cnt16", 64'(cnt16), 64'd0);
`endif
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("mid no stale c%0d", c), 64'(ov16), 64'd0);
      end
      @(posedge clk); #1;

`ifdef FP_CLASSIFY_STATS_EN
      // Four pos_normal handshakes
      for (int b = 0; b < 4; b++) begin
         v16 = 1'b1; d16 = 16'h3C00; daz16 = 1'b0;
         @(posedge clk); #1;
      end
      v16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ecnt16 = '0; ecnt16[24 +: 4] = 4'd4;
      check("stats 4 beats", 64'(cnt16), 64'(ecnt16));
      @(posedge clk); #1;

      // Clear coinciding with a handshake wins
      v16 = 1'b1; d16 = 16'h3C00;
      @(posedge clk); #1 v16 = 1'b0;
      @(posedge clk); #1 clr16 = 1'b1;
      @(negedge clk); check("stats clr hs ov", 64'(ov16), 64'd1);
      @(posedge clk); #1 clr16 = 1'b0;
      @(negedge clk); check("stats clr", 64'(cnt16), 64'd0);
      @(posedge clk); #1;

      // Saturation at 4'hF
      for (int b = 0; b < 20; b++) begin
         v16 = 1'b1; d16 = 16'h3C00;
         @(posedge clk); #1;
      end
      v16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ecnt16 = '0; ecnt16[24 +: 4] = 4'd15;
      check("stats saturate", 64'(cnt16), 64'(ecnt16));
      @(posedge clk); #1;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
